// File: rtl/canyon_rom_loader.sv
// Splits the flat HPS ROM download into per-region write strobes with local addresses,
// counts and checksums accepted bytes, and holds the game core in reset around a download.
module canyon_rom_loader #(
    parameter int unsigned R0_SIZE     = 2048,
    parameter int unsigned R1_SIZE     = 512,
    parameter int unsigned R2_SIZE     = 256,
    parameter int unsigned R3_SIZE     = 256,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned LADDR_W     = 12
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               ioctl_download,
    input  logic               ioctl_wr,
    input  logic [24:0]        ioctl_addr,
    input  logic [7:0]         ioctl_data,
    output logic [3:0]         rom_we,
    output logic [LADDR_W-1:0] rom_addr,
    output logic [7:0]         rom_data,
    output logic               core_reset,
    output logic               load_done,
    output logic               load_error,
    output logic [15:0]        checksum
);

    localparam int unsigned TOTAL  = R0_SIZE + R1_SIZE + R2_SIZE + R3_SIZE;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [24:0]       BASE1     = 25'(R0_SIZE);
    localparam logic [24:0]       BASE2     = 25'(R0_SIZE + R1_SIZE);
    localparam logic [24:0]       BASE3     = 25'(R0_SIZE + R1_SIZE + R2_SIZE);
    localparam logic [24:0]       TOTAL_A   = 25'(TOTAL);
    localparam logic [15:0]       TOTAL_CNT = 16'(TOTAL);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_HOLD,
        S_RUN
    } state_t;

    state_t               state_q, state_d;
    logic                 wr_prev_q, dl_prev_q;
    logic [3:0]           rom_we_q, rom_we_d;
    logic [LADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [7:0]           rom_data_q, rom_data_d;
    logic                 core_reset_q, core_reset_d;
    logic                 load_done_q, load_done_d;
    logic                 load_error_q, load_error_d;
    logic [15:0]          checksum_q, checksum_d;
    logic [15:0]          count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;

    logic wr_evt, dl_rise, dl_fall, start_load;

    assign wr_evt     = ioctl_wr & ~wr_prev_q;
    assign dl_rise    = ioctl_download & ~dl_prev_q;
    assign dl_fall    = ~ioctl_download & dl_prev_q;
    assign start_load = dl_rise & ((state_q == S_IDLE) | (state_q == S_HOLD) | (state_q == S_RUN));

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        rom_we_d     = 4'b0000;
        rom_addr_d   = rom_addr_q;
        rom_data_d   = rom_data_q;
        load_done_d  = load_done_q;
        load_error_d = load_error_q;
        checksum_d   = checksum_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        hold_cnt_d   = hold_cnt_q;

        unique case (state_q)
            S_IDLE: begin
            end
            S_LOAD: begin
                if (wr_evt) begin
                    if (ioctl_addr < TOTAL_A) begin
                        if (ioctl_addr < BASE1) begin
                            rom_we_d   = 4'b0001;
                            rom_addr_d = LADDR_W'(ioctl_addr);
                        end else if (ioctl_addr < BASE2) begin
                            rom_we_d   = 4'b0010;
                            rom_addr_d = LADDR_W'(ioctl_addr - BASE1);
                        end else if (ioctl_addr < BASE3) begin
                            rom_we_d   = 4'b0100;
                            rom_addr_d = LADDR_W'(ioctl_addr - BASE2);
                        end else begin
                            rom_we_d   = 4'b1000;
                            rom_addr_d = LADDR_W'(ioctl_addr - BASE3);
                        end
                        rom_data_d = ioctl_data;
                        if (count_q != 16'hFFFF) begin
                            count_d = count_q + 16'd1;
                        end
                        checksum_d = checksum_q + 16'(ioctl_data);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                // A write on the same cycle as the fall is already folded into count_d
                if (dl_fall) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                load_error_d = (count_q != TOTAL_CNT) | overflow_q;
                hold_cnt_d   = '0;
                state_d      = S_HOLD;
            end
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d     = S_RUN;
                    load_done_d = ~load_error_q;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            S_RUN: begin
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new download restarts from any settled or settling state
        if (start_load) begin
            state_d      = S_LOAD;
            count_d      = '0;
            checksum_d   = '0;
            overflow_d   = 1'b0;
            load_error_d = 1'b0;
            load_done_d  = 1'b0;
        end

        core_reset_d = (state_d != S_RUN);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_prev_q    <= 1'b0;
            dl_prev_q    <= 1'b0;
            rom_we_q     <= 4'b0000;
            rom_addr_q   <= '0;
            rom_data_q   <= 8'd0;
            core_reset_q <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            checksum_q   <= 16'd0;
            count_q      <= 16'd0;
            overflow_q   <= 1'b0;
            hold_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_prev_q    <= ioctl_wr;
            dl_prev_q    <= ioctl_download;
            rom_we_q     <= rom_we_d;
            rom_addr_q   <= rom_addr_d;
            rom_data_q   <= rom_data_d;
            core_reset_q <= core_reset_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
            checksum_q   <= checksum_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    assign rom_we     = rom_we_q;
    assign rom_addr   = rom_addr_q;
    assign rom_data   = rom_data_q;
    assign core_reset = core_reset_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_canyon_rom_loader.sv
// Bench for canyon_rom_loader: a cycle model built from region sizes and download timing,
// compared every cycle, plus hand-computed literal checks at key points.
module tb_canyon_rom_loader;

    localparam int TOTAL = 3072;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic [3:0]  rom_we;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic        core_reset;
    logic        load_done;
    logic        load_error;
    logic [15:0] checksum;

    canyon_rom_loader dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .rom_we         (rom_we),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .core_reset     (core_reset),
        .load_done      (load_done),
        .load_error     (load_error),
        .checksum       (checksum)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: region map from sizes, load outcome and release time from the fall
    int         sizes [4] = '{2048, 512, 256, 256};
    int         m_cyc = 0, m_count = 0, m_sum = 0, m_release = -1, m_err_at = -1;
    bit         m_loading = 0, m_over = 0, m_pend_err = 0, m_prev_wr = 0, m_prev_dl = 0, m_valid = 0;
    logic [3:0] e_we = '0;
    int         e_addr = 0, e_data = 0;
    bit         e_cr = 1, e_done = 0, e_err = 0;

    always @(posedge clk_sys) begin : model
        bit wr_ev, rise, fall;
        int a, base;
        m_cyc++;
        m_valid = 1;
        e_we = '0;
        if (reset) begin
            m_count = 0; m_sum = 0; m_over = 0; m_loading = 0;
            m_release = -1; m_err_at = -1;
            e_addr = 0; e_data = 0; e_cr = 1; e_done = 0; e_err = 0;
            m_prev_wr = 0; m_prev_dl = 0;
        end else begin
            wr_ev = ioctl_wr && !m_prev_wr;
            rise  = ioctl_download && !m_prev_dl;
            fall  = !ioctl_download && m_prev_dl;
            if (rise && !m_loading) begin
                m_loading = 1; m_count = 0; m_sum = 0; m_over = 0;
                e_err = 0; e_done = 0; e_cr = 1; m_release = -1; m_err_at = -1;
            end else if (m_loading) begin
                if (wr_ev) begin
                    a = int'(ioctl_addr);
                    if (a < TOTAL) begin
                        base = 0;
                        for (int r = 0; r < 4; r++) begin
                            if (a >= base && a < base + sizes[r]) begin
                                e_we   = 4'(1 << r);
                                e_addr = a - base;
                            end
                            base += sizes[r];
                        end
                        e_data = int'(ioctl_data);
                        if (m_count < 65535) m_count++;
                        m_sum = (m_sum + int'(ioctl_data)) % 65536;
                    end else begin
                        m_over = 1;
                    end
                end
                if (fall) begin
                    m_loading  = 0;
                    m_pend_err = (m_count != TOTAL) || m_over;
                    m_err_at   = m_cyc + 1;
                    m_release  = m_cyc + 17;
                end
            end
            if (m_cyc == m_err_at) e_err = m_pend_err;
            if (m_cyc == m_release) begin
                e_cr   = 0;
                e_done = !m_pend_err;
            end
            m_prev_wr = ioctl_wr;
            m_prev_dl = ioctl_download;
        end
    end

    always @(negedge clk_sys) begin
        if (m_valid) begin
            check("rom_we", 32'(rom_we), 32'(e_we));
            if (e_we != 4'b0000) begin
                check("rom_addr", 32'(rom_addr), e_addr);
                check("rom_data", 32'(rom_data), e_data);
            end
            check("core_reset", 32'(core_reset), 32'(e_cr));
            check("load_done", 32'(load_done), 32'(e_done));
            check("load_error", 32'(load_error), 32'(e_err));
            check("checksum", 32'(checksum), m_sum);
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_rom_we"}, 32'(rom_we), 0);
        check({tag, "_rom_addr"}, 32'(rom_addr), 0);
        check({tag, "_rom_data"}, 32'(rom_data), 0);
        check({tag, "_core_reset"}, 32'(core_reset), 1);
        check({tag, "_load_done"}, 32'(load_done), 0);
        check({tag, "_load_error"}, 32'(load_error), 0);
        check({tag, "_checksum"}, 32'(checksum), 0);
    endtask

    // One write pulse of 'hold' cycles; strobe is visible at the first negedge after raising wr
    task automatic do_write(input int a, input int d, input int hold, input bit chk,
                            input logic [3:0] xwe, input int xaddr, input bit with_fall);
        @(negedge clk_sys);
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(a);
        ioctl_data = 8'(d);
        if (with_fall) ioctl_download = 1'b0;
        @(negedge clk_sys);
        if (chk) begin
            check("lit_we", 32'(rom_we), 32'(xwe));
            if (xwe != 4'b0000) check("lit_addr", 32'(rom_addr), xaddr);
        end
        repeat (hold - 1) @(negedge clk_sys);
        ioctl_wr = 1'b0;
    endtask

    task automatic load_seq(input int n);
        for (int a = 0; a < n; a++) begin
            case (a)
                2047:    do_write(a, a % 256, 2, 1, 4'b0001, 2047, 0);
                2048:    do_write(a, a % 256, 2, 1, 4'b0010, 0, 0);
                2560:    do_write(a, a % 256, 2, 1, 4'b0100, 0, 0);
                2816:    do_write(a, a % 256, 2, 1, 4'b1000, 0, 0);
                default: do_write(a, a % 256, 2, 0, 4'b0000, 0, 0);
            endcase
        end
    endtask

    task automatic start_dl();
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        @(negedge clk_sys);
    endtask

    // Bounded wait: negedges until core_reset drops
    task automatic wait_release(input int exp);
        int n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk_sys);
            if (core_reset === 1'b0) begin
                n = i;
                break;
            end
        end
        check("release_latency", n, exp);
    endtask

    // Fall applied at a negedge; release edge is 17 posedges after the sampling edge
    task automatic end_dl();
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        wait_release(18);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk_sys);
        check_reset_vals("por");
        reset = 1'b0;

        // Full load; 12 ramps of 0..255 -> 12*32640 mod 65536 = 64000
        start_dl();
        load_seq(TOTAL);
        end_dl();
        check("full_checksum", 32'(checksum), 64000);
        check("full_error", 32'(load_error), 0);
        check("full_done", 32'(load_done), 1);

        // Reload from RUN, then a 3000-byte load whose last write coincides with the fall
        start_dl();
        check("reload_core_reset", 32'(core_reset), 1);
        check("reload_done", 32'(load_done), 0);
        check("reload_checksum", 32'(checksum), 0);
        load_seq(2999);
        do_write(2999, 183, 2, 1, 4'b1000, 183, 1);
        wait_release(16);
        // 11*32640 + sum(0..183) = 375876 mod 65536 = 48196
        check("short_checksum", 32'(checksum), 48196);
        check("short_error", 32'(load_error), 1);
        check("short_done", 32'(load_done), 0);

        // Full load plus one out-of-range write
        start_dl();
        load_seq(TOTAL);
        do_write(5000, 8'h55, 2, 1, 4'b0000, 0, 0);
        end_dl();
        check("oor_checksum", 32'(checksum), 64000);
        check("oor_error", 32'(load_error), 1);
        check("oor_done", 32'(load_done), 0);

        // Five-cycle strobe counts once
        start_dl();
        do_write(10, 42, 5, 1, 4'b0001, 10, 0);
        repeat (3) @(negedge clk_sys);
        end_dl();
        check("held_checksum", 32'(checksum), 42);
        check("held_error", 32'(load_error), 1);

        // Reset mid-load, coinciding with a fresh write event
        start_dl();
        load_seq(100);
        @(negedge clk_sys);
        reset      = 1'b1;
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'd100;
        ioctl_data = 8'd100;
        @(negedge clk_sys);
        check_reset_vals("mid");
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        reset = 1'b0;

        start_dl();
        load_seq(TOTAL);
        end_dl();
        check("after_rst_checksum", 32'(checksum), 64000);
        check("after_rst_done", 32'(load_done), 1);
        check("after_rst_error", 32'(load_error), 0);

        repeat (2) @(negedge clk_sys);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
